// File: rtl/reg_writeback.sv
// Register file and writeback stage: a single pending-write latch with read forwarding,
// CPSR, retire counter and a debug write port that drains the pipeline before writing.
module reg_writeback #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W:0]   wb_result,
  input  logic              wb_we,
  input  logic              wb_half_hi,
  input  logic [3:0]        wb_flags,
  input  logic              wb_flags_we,
  input  logic [ADDR_W-1:0] rd_addr_0,
  input  logic [ADDR_W-1:0] rd_addr_1,
  output logic [DATA_W-1:0] r_val_0,
  output logic [DATA_W-1:0] r_val_1,
  output logic [3:0]        cpsr,
  output logic [31:0]       retire_cnt,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack
);

  typedef enum logic [1:0] {RUN, DRAIN, DWRITE, HOLD} state_t;

  state_t            state;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_dest;
  logic [DATA_W-1:0] pend_data;
  logic              transfer;
  logic [DATA_W-1:0] cur;
  logic [DATA_W-1:0] wdata;
  logic              unused_carry;

  assign unused_carry = wb_result[DATA_W];
  assign wb_ready     = (state == RUN);
  assign transfer     = wb_valid & wb_ready;

  // MOVT merges against the forwarded value so a write still in the latch is not lost
  always_comb begin
    cur = regs[wb_dest];
    if (pend_valid && pend_dest == wb_dest) cur = pend_data;
    wdata = wb_half_hi ? {wb_result[DATA_W-1:16], cur[15:0]} : wb_result[DATA_W-1:0];
  end

  always_comb begin
    r_val_0 = regs[rd_addr_0];
    r_val_1 = regs[rd_addr_1];
    if (pend_valid && pend_dest == rd_addr_0) r_val_0 = pend_data;
    if (pend_valid && pend_dest == rd_addr_1) r_val_1 = pend_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      pend_valid <= 1'b0;
      pend_dest  <= '0;
      pend_data  <= '0;
      cpsr       <= '0;
      retire_cnt <= '0;
      dbg_ack    <= 1'b0;
      state      <= RUN;
    end else begin
      if (pend_valid) regs[pend_dest] <= pend_data;
      pend_valid <= transfer & wb_we;
      if (transfer & wb_we) begin
        pend_dest <= wb_dest;
        pend_data <= wdata;
      end
      if (transfer) begin
        retire_cnt <= retire_cnt + 32'd1;
        if (wb_flags_we) cpsr <= wb_flags;
      end
      dbg_ack <= 1'b0;
      // DWRITE is only entered with the latch empty, so the two regfile writes never collide
      case (state)
        RUN:    if (dbg_req) state <= DRAIN;
        DRAIN:  if (!pend_valid) begin
                  state   <= DWRITE;
                  dbg_ack <= 1'b1;
                end
        DWRITE: begin
                  regs[dbg_addr] <= dbg_wdata;
                  state          <= HOLD;
                end
        HOLD:   if (!dbg_req) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed vector table, debug/reset sequences,
// then randomized traffic against an architectural register model.
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic        wb_ready;
  logic [2:0]  wb_dest;
  logic [32:0] wb_result;
  logic        wb_we;
  logic        wb_half_hi;
  logic [3:0]  wb_flags;
  logic        wb_flags_we;
  logic [2:0]  rd_addr_0;
  logic [2:0]  rd_addr_1;
  logic [31:0] r_val_0;
  logic [31:0] r_val_1;
  logic [3:0]  cpsr;
  logic [31:0] retire_cnt;
  logic        dbg_req;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack;

  int vectors     = 0;
  int miscompares = 0;

  reg_writeback #(.DATA_W(32), .NUM_REGS(8), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_dest(wb_dest), .wb_result(wb_result), .wb_we(wb_we), .wb_half_hi(wb_half_hi),
    .wb_flags(wb_flags), .wb_flags_we(wb_flags_we), .rd_addr_0(rd_addr_0),
    .rd_addr_1(rd_addr_1), .r_val_0(r_val_0), .r_val_1(r_val_1), .cpsr(cpsr),
    .retire_cnt(retire_cnt), .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [2:0]  dest;
    logic [32:0] res;
    logic        we;
    logic        half;
    logic [3:0]  flags;
    logic        fwe;
    logic [2:0]  rd0;
    logic [2:0]  rd1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [3:0]  ecpsr;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vt [13];

  // Architectural view: with forwarding, a read returns the latest accepted write.
  logic [31:0] arch [8];
  logic [3:0]  m_cpsr;
  logic [31:0] m_cnt;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 0; wb_dest = 0; wb_result = '0; wb_we = 0; wb_half_hi = 0;
    wb_flags = 0; wb_flags_we = 0;
  endtask

  task automatic drive(input vec_t v);
    wb_valid = v.valid; wb_dest = v.dest; wb_result = v.res; wb_we = v.we;
    wb_half_hi = v.half; wb_flags = v.flags; wb_flags_we = v.fwe;
    rd_addr_0 = v.rd0; rd_addr_1 = v.rd1;
  endtask

  initial begin
    int acks;
    logic [32:0] res;
    logic [2:0]  d;

    rst_n = 0; idle(); rd_addr_0 = 0; rd_addr_1 = 0;
    dbg_req = 0; dbg_addr = 0; dbg_wdata = '0;
    #22;
    for (int a = 0; a < 8; a++) begin
      rd_addr_0 = 3'(a); rd_addr_1 = 3'(7 - a); #1;
      check("reset_r0", r_val_0, 32'h0);
      check("reset_r1", r_val_1, 32'h0);
    end
    check("reset_cpsr", 32'(cpsr), 32'h0);
    check("reset_cnt", retire_cnt, 32'h0);
    check("reset_ready", 32'(wb_ready), 32'h1);
    check("reset_ack", 32'(dbg_ack), 32'h0);
    @(negedge clk); rst_n = 1;

    //        valid dest res               we half flags  fwe rd0 rd1 e0            e1            cpsr   cnt
    vt[0]  = '{1, 3'd2, 33'h0_1234_5678, 1, 0, 4'h0, 0, 3'd2, 3'd0, 32'h1234_5678, 32'h0,        4'h0, 32'd1};
    vt[1]  = '{0, 3'd0, 33'h0,           0, 0, 4'h0, 0, 3'd2, 3'd0, 32'h1234_5678, 32'h0,        4'h0, 32'd1};
    vt[2]  = '{1, 3'd3, 33'h0_0000_ABCD, 1, 0, 4'h0, 0, 3'd3, 3'd2, 32'h0000_ABCD, 32'h1234_5678, 4'h0, 32'd2};
    vt[3]  = '{1, 3'd3, 33'h0_5555_0000, 1, 1, 4'h0, 0, 3'd3, 3'd2, 32'h5555_ABCD, 32'h1234_5678, 4'h0, 32'd3};
    vt[4]  = '{0, 3'd0, 33'h0,           0, 0, 4'h0, 0, 3'd3, 3'd3, 32'h5555_ABCD, 32'h5555_ABCD, 4'h0, 32'd3};
    vt[5]  = '{1, 3'd1, 33'h0_0000_0001, 1, 0, 4'h0, 0, 3'd1, 3'd0, 32'h1,         32'h0,        4'h0, 32'd4};
    vt[6]  = '{1, 3'd1, 33'h0_0000_0002, 1, 0, 4'h0, 0, 3'd1, 3'd0, 32'h2,         32'h0,        4'h0, 32'd5};
    vt[7]  = '{0, 3'd0, 33'h0,           0, 0, 4'h0, 0, 3'd1, 3'd3, 32'h2,         32'h5555_ABCD, 4'h0, 32'd5};
    vt[8]  = '{1, 3'd2, 33'h1_FFFF_FFFF, 0, 0, 4'h2, 1, 3'd2, 3'd1, 32'h1234_5678, 32'h2,        4'h2, 32'd6};
    vt[9]  = '{0, 3'd2, 33'h0,           1, 0, 4'hF, 1, 3'd2, 3'd1, 32'h1234_5678, 32'h2,        4'h2, 32'd6};
    vt[10] = '{1, 3'd4, 33'h1_AAAA_FFFF, 1, 1, 4'h0, 0, 3'd4, 3'd3, 32'hAAAA_0000, 32'h5555_ABCD, 4'h2, 32'd7};
    vt[11] = '{1, 3'd0, 33'h0_1111_1111, 0, 0, 4'h0, 0, 3'd4, 3'd0, 32'hAAAA_0000, 32'h0,        4'h2, 32'd8};
    vt[12] = '{1, 3'd0, 33'h1_8000_0000, 1, 0, 4'h9, 1, 3'd0, 3'd4, 32'h8000_0000, 32'hAAAA_0000, 4'h9, 32'd9};

    for (int i = 0; i < 13; i++) begin
      drive(vt[i]);
      step();
      check($sformatf("v%0d_r0", i), r_val_0, vt[i].e0);
      check($sformatf("v%0d_r1", i), r_val_1, vt[i].e1);
      check($sformatf("v%0d_cpsr", i), 32'(cpsr), 32'(vt[i].ecpsr));
      check($sformatf("v%0d_cnt", i), retire_cnt, vt[i].ecnt);
      check($sformatf("v%0d_ready", i), 32'(wb_ready), 32'h1);
    end

    // Debug write requested while a write to the same register is accepted
    wb_valid = 1; wb_dest = 5; wb_result = 33'h7; wb_we = 1; wb_half_hi = 0; wb_flags_we = 0;
    dbg_req = 1; dbg_addr = 5; dbg_wdata = 32'hDEAD_BEEF;
    rd_addr_0 = 5; rd_addr_1 = 6;
    step();
    check("dbg_fwd_r5", r_val_0, 32'h7);
    wb_dest = 6; wb_result = 33'h99;
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      check($sformatf("dbg_ready_c%0d", c), 32'(wb_ready), 32'h0);
      if (dbg_ack === 1'b1) acks++;
      step();
    end
    check("dbg_ready_hold", 32'(wb_ready), 32'h0);
    check("dbg_ack_pulses", 32'(acks), 32'h1);
    check("dbg_r5", r_val_0, 32'hDEAD_BEEF);
    check("dbg_r6_blocked", r_val_1, 32'h0);
    check("dbg_cnt", retire_cnt, 32'd10);
    idle(); dbg_req = 0;
    step();
    check("dbg_ready_back", 32'(wb_ready), 32'h1);
    check("dbg_r5_after", r_val_0, 32'hDEAD_BEEF);

    // Reset while draining with a pending write
    wb_valid = 1; wb_dest = 7; wb_result = 33'h77; wb_we = 1; dbg_req = 1; dbg_addr = 2;
    rd_addr_0 = 7; rd_addr_1 = 5;
    step();
    idle();
    check("drain_pend_r7", r_val_0, 32'h77);
    check("drain_ready", 32'(wb_ready), 32'h0);
    #2 rst_n = 0;
    #1;
    check("rst_r7", r_val_0, 32'h0);
    check("rst_r5", r_val_1, 32'h0);
    check("rst_ready", 32'(wb_ready), 32'h1);
    check("rst_cnt", retire_cnt, 32'h0);
    dbg_req = 0;
    @(negedge clk); rst_n = 1;
    step();
    check("post_rst_r7", r_val_0, 32'h0);
    check("post_rst_ready", 32'(wb_ready), 32'h1);
    check("post_rst_ack", 32'(dbg_ack), 32'h0);

    // Randomized traffic against the architectural model
    for (int a = 0; a < 8; a++) arch[a] = '0;
    m_cpsr = '0; m_cnt = '0;
    for (int n = 0; n < 400; n++) begin
      res = {1'($urandom_range(0, 1)), 32'($urandom())};
      d   = 3'($urandom_range(0, 7));
      wb_valid = 1'($urandom_range(0, 3) != 0);
      wb_dest = d; wb_result = res;
      wb_we = 1'($urandom_range(0, 3) != 0);
      wb_half_hi = 1'($urandom_range(0, 3) == 0);
      wb_flags = 4'($urandom_range(0, 15));
      wb_flags_we = 1'($urandom_range(0, 1));
      rd_addr_0 = 3'($urandom_range(0, 7));
      rd_addr_1 = 3'($urandom_range(0, 7));
      if (wb_valid) begin
        if (wb_we) arch[d] = wb_half_hi ? {res[31:16], arch[d][15:0]} : res[31:0];
        if (wb_flags_we) m_cpsr = wb_flags;
        m_cnt = m_cnt + 1;
      end
      step();
      check("rnd_r0", r_val_0, arch[rd_addr_0]);
      check("rnd_r1", r_val_1, arch[rd_addr_1]);
      check("rnd_cpsr", 32'(cpsr), 32'(m_cpsr));
      check("rnd_cnt", retire_cnt, m_cnt);
      check("rnd_ready", 32'(wb_ready), 32'h1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
